// File: rtl/hex_scan_driver.sv
// hex_scan_driver: time-multiplexed hex display driver.
// A prescaler divides clk into digit slots; each slot lights one digit,
// PWM-modulated by 'brightness'. Inputs are captured into shadow registers
// once per scan frame so a frame never shows a mix of old and new values.
// seg and an are registered and optionally inverted for active-low pins.
// Optional feature: define HEXSEG_LEADING_ZERO_BLANK_EN to blank leading
// zero digits (digit 0 is never blanked by that rule).
module hex_scan_driver #(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 100000,
  parameter int BRIGHT_W   = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int PS_W  = $clog2(PRESCALE);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic              INV      = (ACTIVE_LOW != 0);
  localparam logic [7:0]        SEG_OFF  = {8{INV}};
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{INV}};

  logic [PS_W-1:0]     presc;
  logic [IDX_W-1:0]    idx;
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic [4*DIGITS-1:0] sh_value;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_en;

  logic                tick;
  logic                capture;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_en;
  logic                cur_lz;
  logic [DIGITS-1:0]   lz_mask;
  logic                lit;
  logic [7:0]          seg_ah;
  logic [DIGITS-1:0]   an_ah;

  // Active-high segment pattern (gfedcba) for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // A slot ends on the prescaler wrap; the frame ends when the last digit's slot ends.
  assign tick    = (presc == PS_LAST);
  assign capture = tick && (idx == IDX_LAST);

  // Prescaler: counts 0..PRESCALE-1 and wraps.
  always_ff @(posedge clk or posedge res) begin
    if (res)       presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // Digit index: advances once per slot, wrapping after the last digit.
  always_ff @(posedge clk or posedge res) begin
    if (res)          idx <= '0;
    else if (capture) idx <= '0;
    else if (tick)    idx <= idx + 1'b1;
  end

  // Free-running PWM counter.
  always_ff @(posedge clk or posedge res) begin
    if (res) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Shadow capture at frame boundary; shadow enables reset to 0 keep the
  // display blank until the first full frame has been captured.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sh_value <= '0;
      sh_dp    <= '0;
      sh_en    <= '0;
    end else if (capture) begin
      sh_value <= value;
      sh_dp    <= dp;
      sh_en    <= digit_en;
    end
  end

  // frame_start marks the first cycle shown with freshly captured shadows.
  always_ff @(posedge clk or posedge res) begin
    if (res) frame_start <= 1'b0;
    else     frame_start <= capture;
  end

  // Select the shadow fields of the digit currently being scanned.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    cur_lz  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib = sh_value[4*i +: 4];
        cur_dp  = sh_dp[i];
        cur_en  = sh_en[i];
        cur_lz  = lz_mask[i];
      end
    end
  end

`ifdef HEXSEG_LEADING_ZERO_BLANK_EN
  logic lz_run;

  // Leading-zero mask: digit i>0 blanks when it and every higher nibble are 0.
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run     = lz_run && (sh_value[4*i +: 4] == 4'h0);
      lz_mask[i] = lz_run;
    end
  end
`else
  assign lz_mask = '0;
`endif

  // Lit decision and active-high pattern for the current digit.
  always_comb begin
    lit    = cur_en && !cur_lz && (pwm_cnt <= brightness);
    seg_ah = lit ? {cur_dp, hex7(cur_nib)} : 8'h00;
    an_ah  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      an_ah[i] = lit && (idx == IDX_W'(i));
    end
  end

  // Registered pins with polarity applied; held off while in reset.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= seg_ah ^ {8{INV}};
      an  <= an_ah ^ {DIGITS{INV}};
    end
  end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Bench for hex_scan_driver at DIGITS=4, PRESCALE=4, BRIGHT_W=2, ACTIVE_LOW=1.
// Reference model works from the edge count k since reset release:
// after k edges the scan sits at digit (k/4)%4 with pwm k%4, shadows are
// reloaded at every 16th edge, and pins show the state from one edge earlier.
module tb_hex_scan_driver;

  logic        clk = 1'b0;
  logic        res;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic [1:0]  brightness;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  int          k;
  logic [15:0] sh_val;
  logic [3:0]  sh_dp;
  logic [3:0]  sh_en;
  logic [6:0]  hex_tab [16];

  hex_scan_driver #(
    .DIGITS(4), .PRESCALE(4), .BRIGHT_W(2), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .res(res), .value(value), .dp(dp), .digit_en(digit_en),
    .brightness(brightness), .seg(seg), .an(an), .frame_start(frame_start)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h k=%0d", tag, obs, exp, k);
    end
  endtask

  function automatic logic lz_blank(input int d);
`ifdef HEXSEG_LEADING_ZERO_BLANK_EN
    if (d == 0) return 1'b0;
    for (int j = d; j < 4; j++) if (sh_val[j*4 +: 4] != 4'h0) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // One clock edge: predict pins from the model, update shadows, compare.
  task automatic step();
    int         d, pw;
    logic [3:0] nib;
    logic       lit;
    logic [7:0] eseg;
    logic [3:0] ean;
    logic       efs;
    logic [1:0] br;
    br = brightness;
    @(posedge clk);
    k++;
    d   = ((k - 1) / 4) % 4;
    pw  = (k - 1) % 4;
    nib = sh_val[d*4 +: 4];
    lit = sh_en[d] && (pw <= int'(br)) && !lz_blank(d);
    eseg = lit ? ~{sh_dp[d], hex_tab[nib]} : 8'hFF;
    ean  = lit ? ~(4'b0001 << d) : 4'hF;
    efs  = (k % 16 == 0);
    if (k % 16 == 0) begin
      sh_val = value;
      sh_dp  = dp;
      sh_en  = digit_en;
    end
    #1;
    check("seg", seg, eseg);
    check("an", {4'h0, an}, {4'h0, ean});
    check("frame_start", {7'h0, frame_start}, {7'h0, efs});
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Assert reset between edges, confirm pins go off at once, then release.
  task automatic do_reset(input int hold);
    res = 1'b1;
    #1;
    check("rst_seg", seg, 8'hFF);
    check("rst_an", {4'h0, an}, 8'h0F);
    check("rst_fs", {7'h0, frame_start}, 8'h00);
    repeat (hold) @(posedge clk);
    #1;
    res    = 1'b0;
    k      = 0;
    sh_val = '0;
    sh_dp  = '0;
    sh_en  = '0;
  endtask

  initial begin
    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    k = 0;
    value = 16'h12AF;
    dp = 4'h0;
    digit_en = 4'hF;
    brightness = 2'd3;
    res = 1'b0;
    #2;
    do_reset(2);

    // Blank first frame, then F,A,2,1 across the anodes.
    run(48);

    // Reduced duty.
    brightness = 2'd0;
    run(32);
    brightness = 2'd1;
    run(32);
    brightness = 2'd3;

    // Mid-frame value change must wait for the next frame.
    value = 16'h1234;
    run(20);
    value = 16'h5678;
    run(28);

    // Per-digit enables and decimal points.
    digit_en = 4'b0101;
    dp = 4'b0001;
    run(32);
    dp = 4'b1111;
    digit_en = 4'hF;
    run(32);
    dp = 4'h0;

    // Leading zeros.
    value = 16'h0030;
    run(32);
    value = 16'h0000;
    run(32);

    // Reset mid-slot at digit 2, prescaler 1.
    value = 16'hBEEF;
    while (k % 16 != 9) step();
    do_reset(1);
    run(40);

    // Randomized inputs.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) value = 16'($urandom);
      if ($urandom_range(0, 7) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 7) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 9) == 0) brightness = 2'($urandom_range(0, 3));
      if (i == 300) do_reset($urandom_range(1, 3));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
